// File: rtl/lsu_xlat_req_ctrl_if.sv
// Bus bundle between LSU address generation, the MMU data port and the load/store consumer.
// The master modport is the translation request controller; slave is its environment.
interface lsu_xlat_req_ctrl_if #(
  parameter int unsigned TRANS_ID_BITS = 3
) ();

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  logic                     flush_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [63:0]              in_vaddr_i;
  logic [1:0]               in_size_i;
  logic                     in_is_store_i;
  logic [TRANS_ID_BITS-1:0] in_trans_id_i;
  logic                     lsu_req_o;
  logic [63:0]              lsu_vaddr_o;
  logic                     lsu_is_store_o;
  exception_t               misaligned_ex_o;
  logic                     lsu_dtlb_hit_i;
  logic                     lsu_valid_i;
  logic [63:0]              lsu_paddr_i;
  exception_t               lsu_exception_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [63:0]              out_paddr_o;
  exception_t               out_exception_o;
  logic                     out_is_store_o;
  logic [TRANS_ID_BITS-1:0] out_trans_id_o;
  logic                     xlat_miss_o;

  modport master (
    input  flush_i, in_valid_i, in_vaddr_i, in_size_i, in_is_store_i, in_trans_id_i,
    input  lsu_dtlb_hit_i, lsu_valid_i, lsu_paddr_i, lsu_exception_i, out_ready_i,
    output in_ready_o, lsu_req_o, lsu_vaddr_o, lsu_is_store_o, misaligned_ex_o,
    output out_valid_o, out_paddr_o, out_exception_o, out_is_store_o, out_trans_id_o,
    output xlat_miss_o
  );

  modport slave (
    output flush_i, in_valid_i, in_vaddr_i, in_size_i, in_is_store_i, in_trans_id_i,
    output lsu_dtlb_hit_i, lsu_valid_i, lsu_paddr_i, lsu_exception_i, out_ready_i,
    input  in_ready_o, lsu_req_o, lsu_vaddr_o, lsu_is_store_o, misaligned_ex_o,
    input  out_valid_o, out_paddr_o, out_exception_o, out_is_store_o, out_trans_id_o,
    input  xlat_miss_o
  );

endinterface

// File: rtl/lsu_xlat_req_ctrl.sv
// Translation request controller: accepts one LSU op, checks alignment, re-issues the MMU
// request until a translation or fault returns, then holds the result until consumed.
module lsu_xlat_req_ctrl #(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  lsu_xlat_req_ctrl_if.master bus
);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [63:0] LdAddrMisaligned = 64'd4;
  localparam logic [63:0] StAddrMisaligned = 64'd6;

  typedef enum logic [1:0] {StIdle, StXlat, StResult} state_e;

  state_e                   r_state, w_state_next;
  logic [63:0]              r_vaddr;
  logic                     r_is_store;
  logic [TRANS_ID_BITS-1:0] r_trans_id;
  exception_t               r_mis_ex;
  logic                     r_req;
  logic                     r_first;
  logic                     r_miss;
  logic [63:0]              r_paddr;
  exception_t               r_ex;

  logic       w_misaligned;
  exception_t w_mis_ex;
  logic       w_accept;
  logic       w_honour;
  logic       w_lsu_req;
  logic       w_in_ready;

  always_comb begin
    w_misaligned = 1'b0;
    unique case (bus.in_size_i)
      2'b00: w_misaligned = 1'b0;
      2'b01: w_misaligned = bus.in_vaddr_i[0];
      2'b10: w_misaligned = |bus.in_vaddr_i[1:0];
      2'b11: w_misaligned = |bus.in_vaddr_i[2:0];
      default: w_misaligned = 1'b0;
    endcase
    w_mis_ex = '0;
    if (w_misaligned) begin
      w_mis_ex.cause = bus.in_is_store_i ? StAddrMisaligned : LdAddrMisaligned;
      w_mis_ex.tval  = bus.in_vaddr_i;
      w_mis_ex.valid = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_honour     = 1'b0;
    w_lsu_req    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
        if (bus.in_valid_i && !bus.flush_i) begin
          w_accept     = 1'b1;
          w_state_next = StXlat;
        end
      end
      StXlat: begin
        // A valid without our previous-cycle request is a stale response; drop it.
        w_lsu_req = !bus.flush_i && !(bus.lsu_valid_i && r_req);
        w_honour  = bus.lsu_valid_i && r_req && !bus.flush_i;
        if (bus.flush_i)  w_state_next = StIdle;
        else if (w_honour) w_state_next = StResult;
      end
      StResult: begin
        if (bus.flush_i || bus.out_ready_i) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_vaddr    <= '0;
      r_is_store <= 1'b0;
      r_trans_id <= '0;
      r_mis_ex   <= '0;
      r_req      <= 1'b0;
      r_first    <= 1'b0;
      r_miss     <= 1'b0;
      r_paddr    <= '0;
      r_ex       <= '0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_lsu_req;
      r_miss  <= w_lsu_req && r_first && !bus.lsu_dtlb_hit_i;
      if (w_accept) begin
        r_vaddr    <= bus.in_vaddr_i;
        r_is_store <= bus.in_is_store_i;
        r_trans_id <= bus.in_trans_id_i;
        r_mis_ex   <= w_mis_ex;
        r_first    <= 1'b1;
      end else if (w_lsu_req) begin
        r_first <= 1'b0;
      end
      if (w_honour) begin
        r_paddr <= bus.lsu_paddr_i;
        r_ex    <= bus.lsu_exception_i;
      end
    end
  end

  assign bus.in_ready_o      = w_in_ready;
  assign bus.lsu_req_o       = w_lsu_req;
  assign bus.lsu_vaddr_o     = (r_state == StXlat) ? r_vaddr : '0;
  assign bus.lsu_is_store_o  = (r_state == StXlat) ? r_is_store : 1'b0;
  assign bus.misaligned_ex_o = (r_state == StXlat) ? r_mis_ex : '0;
  assign bus.out_valid_o     = (r_state == StResult);
  assign bus.out_paddr_o     = r_paddr;
  assign bus.out_exception_o = r_ex;
  assign bus.out_is_store_o  = r_is_store;
  assign bus.out_trans_id_o  = r_trans_id;
  assign bus.xlat_miss_o     = r_miss;

endmodule
